// File: rtl/stack_pkg.sv
// Shared definitions for the LIFO stack controller: widths, bus field map, FSM encoding.
package stack_pkg;

    localparam int STACK_DW = 32;
    localparam int STACK_AW = 5;

    // Field positions inside the {we, addr, data} memory bus for the default widths.
    localparam int WE_BIT  = 37;
    localparam int ADDR_HI = 36;
    localparam int ADDR_LO = 32;
    localparam int DATA_HI = 31;
    localparam int DATA_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_WT   = 2'd3
    } stack_state_e;

endpackage

// File: rtl/stack_ctrl.sv
// LIFO stack controller driving an external synchronous RAM through a registered
// {we, addr, data} bus. Pushes take two cycles, pops three (RAM read latency is one).
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DW = STACK_DW,
    parameter int AW = STACK_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DW-1:0]     din,
    input  logic              err_clr,
    output logic              ready,
    output logic [DW-1:0]     dout,
    output logic              dout_valid,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              udf,
    output logic [AW+DW:0]    mem_bus,
    input  logic [DW-1:0]     mem_q
);

    localparam logic [AW:0] SP_ZERO = {(AW+1){1'b0}};
    localparam logic [AW:0] SP_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] SP_FULL = {1'b1, {AW{1'b0}}};

    stack_state_e      r_state;
    stack_state_e      w_state_nxt;
    logic [AW:0]       r_sp;
    logic [AW:0]       w_sp_nxt;
    logic [AW:0]       w_top;
    logic [AW+DW:0]    r_mem_bus;
    logic [AW+DW:0]    w_bus_nxt;
    logic [DW-1:0]     r_dout;
    logic [DW-1:0]     w_dout_nxt;
    logic              r_dout_valid;
    logic              w_dv_nxt;
    logic              r_full;
    logic              r_empty;
    logic              r_ready;
    logic              r_ovf;
    logic              r_udf;
    logic              w_ovf_set;
    logic              w_udf_set;

    // Top-of-stack slot; only used when the stack is known to be non-empty.
    assign w_top = r_sp - SP_ONE;

    // Next-state and datapath decode; requests are only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_sp_nxt    = r_sp;
        w_bus_nxt   = r_mem_bus;
        w_dout_nxt  = r_dout;
        w_dv_nxt    = 1'b0;
        w_ovf_set   = 1'b0;
        w_udf_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (push) begin
                    // Push wins over a simultaneous pop; the pop must be re-issued.
                    if (r_full) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_bus_nxt   = {1'b1, r_sp[AW-1:0], din};
                        w_state_nxt = ST_WR;
                    end
                end else if (pop) begin
                    if (r_empty) begin
                        w_udf_set = 1'b1;
                    end else begin
                        w_bus_nxt   = {1'b0, w_top[AW-1:0], {DW{1'b0}}};
                        w_state_nxt = ST_RD;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WR: begin
                // The RAM takes the write on the edge that ends this state.
                w_sp_nxt          = r_sp + SP_ONE;
                w_bus_nxt[AW+DW]  = 1'b0;
                w_state_nxt       = ST_IDLE;
            end
            ST_RD: begin
                w_state_nxt = ST_WT;
            end
            ST_WT: begin
                // Read data is valid now, one cycle after the address edge.
                w_dout_nxt  = mem_q;
                w_dv_nxt    = 1'b1;
                w_sp_nxt    = r_sp - SP_ONE;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, pointer, bus and status registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sp         <= SP_ZERO;
            r_mem_bus    <= {(AW+DW+1){1'b0}};
            r_dout       <= {DW{1'b0}};
            r_dout_valid <= 1'b0;
            r_full       <= 1'b0;
            r_empty      <= 1'b1;
            r_ready      <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_sp         <= w_sp_nxt;
            r_mem_bus    <= w_bus_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dv_nxt;
            r_full       <= (w_sp_nxt == SP_FULL);
            r_empty      <= (w_sp_nxt == SP_ZERO);
            r_ready      <= (w_state_nxt == ST_IDLE);
        end
    end

    // Sticky error flags; a clear in the same cycle as a new error wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (err_clr) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= r_ovf | w_ovf_set;
            r_udf <= r_udf | w_udf_set;
        end
    end

    assign ready      = r_ready;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign count      = r_sp;
    assign full       = r_full;
    assign empty      = r_empty;
    assign ovf        = r_ovf;
    assign udf        = r_udf;
    assign mem_bus    = r_mem_bus;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl with a behavioural 32x32 synchronous RAM.

// Behavioural RAM: write on we, registered read with one-cycle latency.
module stack_ram (
    input  logic        clk,
    input  logic [37:0] bus,
    output logic [31:0] q
);
    logic [31:0] mem [0:31];
    // Synchronous write and registered read of the addressed word.
    always @(posedge clk) begin
        if (bus[37]) mem[bus[36:32]] <= bus[31:0];
        q <= mem[bus[36:32]];
    end
endmodule

module tb_stack_ctrl;
    import stack_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        push, pop, err_clr;
    logic [31:0] din;
    logic        ready, dout_valid, full, empty, ovf, udf;
    logic [31:0] dout, mem_q;
    logic [5:0]  count;
    logic [37:0] mem_bus;

    int n_checks = 0;
    int n_fail   = 0;
    int dv_cnt   = 0;
    int we_cnt   = 0;
    logic prev_dv = 1'b0;

    logic [31:0] model_stk[$];
    logic [31:0] exp_q[$];

    stack_ctrl dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din(din), .err_clr(err_clr),
        .ready(ready), .dout(dout), .dout_valid(dout_valid), .count(count),
        .full(full), .empty(empty), .ovf(ovf), .udf(udf),
        .mem_bus(mem_bus), .mem_q(mem_q)
    );

    stack_ram u_ram (.clk(clk), .bus(mem_bus), .q(mem_q));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every dout_valid pulse must match the oldest expected pop.
    always @(negedge clk) begin
        if (!rst && dout_valid) begin
            dv_cnt++;
            check_eq("dv_single", {63'd0, prev_dv}, 64'd0);
            if (exp_q.size() == 0) begin
                check_eq("dv_unexpected", 64'd1, 64'd0);
            end else begin
                check_eq("pop_data", {32'd0, dout}, {32'd0, exp_q.pop_front()});
            end
        end
        if (!rst && mem_bus[WE_BIT]) we_cnt++;
        prev_dv = dout_valid;
    end

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready) break;
        end
        check_eq("ready_timeout", {63'd0, ready}, 64'd1);
    endtask

    task automatic do_push(input logic [31:0] d);
        wait_ready();
        push = 1'b1;
        din  = d;
        if (model_stk.size() < 32) model_stk.push_back(d);
        @(posedge clk);
        #1 push = 1'b0;
        wait_ready();
    endtask

    task automatic do_pop();
        wait_ready();
        pop = 1'b1;
        if (model_stk.size() > 0) exp_q.push_back(model_stk.pop_back());
        @(posedge clk);
        #1 pop = 1'b0;
        wait_ready();
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"}, {63'd0, ready}, 64'd1);
        check_eq({tag, "_empty"}, {63'd0, empty}, 64'd1);
        check_eq({tag, "_full"},  {63'd0, full}, 64'd0);
        check_eq({tag, "_count"}, {58'd0, count}, 64'd0);
        check_eq({tag, "_bus"},   {26'd0, mem_bus}, 64'd0);
        check_eq({tag, "_dout"},  {32'd0, dout}, 64'd0);
        check_eq({tag, "_dv"},    {63'd0, dout_valid}, 64'd0);
        check_eq({tag, "_flags"}, {62'd0, ovf, udf}, 64'd0);
    endtask

    initial begin
        logic [31:0] saved;
        int          dv0, we0;
        rst = 1'b1; push = 1'b0; pop = 1'b0; err_clr = 1'b0; din = 32'd0;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst = 1'b0;

        // Mid-cycle asynchronous reset during a write.
        do_push(32'h0000_0005);
        do_pop();
        wait_ready();
        push = 1'b1; din = 32'h0000_0007;
        @(posedge clk);
        #1 push = 1'b0;
        #1 check_eq("wr_we_high", {63'd0, mem_bus[WE_BIT]}, 64'd1);
        rst = 1'b1;
        #1 check_reset_vals("async");
        model_stk.delete();
        @(negedge clk);
        rst = 1'b0;

        // LIFO order.
        dv0 = dv_cnt;
        do_push(32'h1111_1111);
        do_push(32'h2222_2222);
        do_push(32'h3333_3333);
        check_eq("lifo_count", {58'd0, count}, 64'd3);
        repeat (3) do_pop();
        @(negedge clk);
        check_eq("lifo_pulses", dv_cnt - dv0, 64'd3);
        check_eq("lifo_empty", {63'd0, empty}, 64'd1);

        // Fill, overflow, drain.
        for (int i = 0; i < 32; i++) do_push(i);
        check_eq("full_flag", {63'd0, full}, 64'd1);
        check_eq("full_count", {58'd0, count}, 64'd32);
        we0 = we_cnt;
        do_push(32'hDEAD_BEEF);
        @(negedge clk);
        check_eq("ovf_set", {63'd0, ovf}, 64'd1);
        check_eq("ovf_no_we", we_cnt - we0, 64'd0);
        check_eq("ovf_count", {58'd0, count}, 64'd32);
        do_pop();
        check_eq("after_pop_dout", {32'd0, dout}, 64'd31);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("ovf_clr", {63'd0, ovf}, 64'd0);
        repeat (31) do_pop();
        @(negedge clk);
        check_eq("drain_empty", {63'd0, empty}, 64'd1);

        // Underflow.
        saved = dout;
        dv0 = dv_cnt;
        do_pop();
        @(negedge clk);
        check_eq("udf_set", {63'd0, udf}, 64'd1);
        check_eq("udf_dout", {32'd0, dout}, {32'd0, saved});
        check_eq("udf_ready", {63'd0, ready}, 64'd1);
        check_eq("udf_no_dv", dv_cnt - dv0, 64'd0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("udf_clr", {63'd0, udf}, 64'd0);
        // Clear beats a same-cycle underflow.
        pop = 1'b1; err_clr = 1'b1;
        @(negedge clk);
        pop = 1'b0; err_clr = 1'b0;
        check_eq("clr_priority", {63'd0, udf}, 64'd0);

        // Simultaneous push+pop, then pop held during WR.
        we0 = we_cnt;
        wait_ready();
        push = 1'b1; pop = 1'b1; din = 32'hA5A5_A5A5;
        model_stk.push_back(32'hA5A5_A5A5);
        @(posedge clk);
        #1 push = 1'b0; pop = 1'b0;
        wait_ready();
        check_eq("sim_count", {58'd0, count}, 64'd1);
        check_eq("sim_we", we_cnt - we0, 64'd1);
        push = 1'b1; din = 32'h0BAD_F00D;
        model_stk.push_back(32'h0BAD_F00D);
        @(posedge clk);
        #1 push = 1'b0;
        @(negedge clk);
        pop = 1'b1;
        @(posedge clk);
        #1 pop = 1'b0;
        @(negedge clk);
        check_eq("busy_ready", {63'd0, ready}, 64'd1);
        check_eq("busy_count", {58'd0, count}, 64'd2);
        check_eq("busy_no_rd", {26'd0, mem_bus}, {26'd0, 1'b0, 5'd1, 32'h0BAD_F00D});
        do_pop();
        do_pop();

        // Reset during WT of a pop.
        do_push(32'h0000_00CC);
        wait_ready();
        dv0 = dv_cnt;
        pop = 1'b1;
        @(posedge clk);
        #1 pop = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        model_stk.delete();
        #1 check_eq("wt_rst_dv", {63'd0, dout_valid}, 64'd0);
        check_eq("wt_rst_count", {58'd0, count}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("wt_rst_nopulse", dv_cnt - dv0, 64'd0);
        check_eq("wt_rst_empty", {63'd0, empty}, 64'd1);
        check_eq("sb_drained", exp_q.size(), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
